// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared constants for the RV32I pipeline
package riscv_pipe_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/grant/response bundle
interface fetch_stage_if #(
    parameter int XLEN = riscv_pipe_pkg::XLEN
);
    logic            IMemReq;
    logic [XLEN-1:0] IMemAddr;
    logic            IMemGnt;
    logic            IMemRValid;
    logic [XLEN-1:0] IMemRData;

    modport master (
        output IMemReq, IMemAddr,
        input  IMemGnt, IMemRValid, IMemRData
    );

    modport slave (
        input  IMemReq, IMemAddr,
        output IMemGnt, IMemRValid, IMemRData
    );
endinterface

// File: rtl/fetch_stage_fifo.sv
// rtl/fetch_stage_fifo.sv - small synchronous FIFO with clear and occupancy count
module fetch_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, in-order imem requests, prefetch FIFO, IF/ID register
module fetch_stage #(
    parameter int              XLEN       = riscv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pipe_pkg::RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    fetch_stage_if.master    imem,
    output logic [XLEN-1:0]  InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(riscv_pipe_pkg::NOP_INSTR);

    logic [XLEN-1:0]   pcf;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     pf_count;
    logic [CW-1:0]     tag_count;
    logic [CW:0]       inflight_total;
    logic              grant;
    logic              resp_live;
    logic              ifid_adv;
    logic              bypass;
    logic              pf_push;
    logic              pf_pop;
    logic              pf_full;
    logic              pf_empty;
    logic              tag_full;
    logic              tag_empty;
    logic [2*XLEN-1:0] pf_rdata;
    logic [XLEN-1:0]   tag_head;
    logic              ld_real;
    logic [XLEN-1:0]   ld_pc;
    logic [XLEN-1:0]   ld_instr;

    // Buffered words plus in-flight requests never exceed FIFO_DEPTH, so the FIFO cannot overflow.
    assign inflight_total = {1'b0, pf_count} + {1'b0, outstanding};
    assign imem.IMemReq   = rst_n & ~StallF & ~PCSrcE &
                            (inflight_total < (CW+1)'(FIFO_DEPTH));
    assign imem.IMemAddr  = pcf;

    assign grant           = imem.IMemReq & imem.IMemGnt;
    assign resp_live       = imem.IMemRValid & ~PCSrcE & (discard == '0);
    assign ifid_adv        = ~StallD & ~FlushD & ~PCSrcE;
    assign bypass          = resp_live & pf_empty & ifid_adv;
    assign pf_push         = resp_live & ~bypass;
    assign pf_pop          = ifid_adv & ~pf_empty;
    assign outstanding_nxt = outstanding + CW'(grant) - CW'(imem.IMemRValid);

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_prefetch (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pf_push),
        .pop   (pf_pop),
        .clear (PCSrcE),
        .wdata ({tag_head, imem.IMemRData}),
        .rdata (pf_rdata),
        .full  (pf_full),
        .empty (pf_empty),
        .count (pf_count)
    );

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tags (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .pop   (resp_live),
        .clear (PCSrcE),
        .wdata (pcf),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    always_comb begin
        ld_real  = ~pf_empty | bypass;
        ld_pc    = pf_empty ? tag_head : pf_rdata[2*XLEN-1:XLEN];
        ld_instr = pf_empty ? imem.IMemRData : pf_rdata[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf         <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (PCSrcE) begin
                pcf     <= PCTargetE;
                discard <= outstanding_nxt;
            end else begin
                if (grant) pcf <= pcf + XLEN'(4);
                if (imem.IMemRValid && discard != '0) discard <= discard - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (PCSrcE || (!StallD && FlushD)) begin
            ValidD <= 1'b0;
            InstrD <= NOP;
        end else if (!StallD) begin
            if (ld_real) begin
                ValidD   <= 1'b1;
                InstrD   <= ld_instr;
                PCD      <= ld_pc;
                PCPlus4D <= ld_pc + XLEN'(4);
            end else begin
                ValidD <= 1'b0;
                InstrD <= NOP;
            end
        end
    end

    a_pf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(pf_push && pf_full));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(grant && tag_full));
    a_tag_present: assert property (@(posedge clk) disable iff (!rst_n) !(resp_live && tag_empty));
    a_tag_bounded: assert property (@(posedge clk) disable iff (!rst_n) tag_count <= outstanding);
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (imem),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        infl[$];
    logic [31:0] dlog[$];
    int          total, bad, cyc, lat, max_infl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at the falling edge: records grants and consumed instructions, then advances one cycle.
    task automatic tick();
        req_t r;
        if (imem.IMemReq && imem.IMemGnt) begin
            r.addr = imem.IMemAddr;
            r.due  = cyc + lat;
            infl.push_back(r);
            if (infl.size() > max_infl) max_infl = infl.size();
        end
        if (ValidD && !StallD && !FlushD && !PCSrcE) dlog.push_back(PCD);
        @(posedge clk);
        #1;
        cyc++;
        if (infl.size() > 0 && infl[0].due == cyc) begin
            imem.IMemRValid = 1'b1;
            imem.IMemRData  = infl[0].addr + 32'h100;
            void'(infl.pop_front());
        end else begin
            imem.IMemRValid = 1'b0;
            imem.IMemRData  = '0;
        end
    endtask

    task automatic restart(input int l);
        rst_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem.IMemGnt = 1'b1; imem.IMemRValid = 1'b0; imem.IMemRData = '0;
        infl.delete();
        dlog.delete();
        max_infl = 0;
        lat = l;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic check_log(input string tag, input int n, input logic [31:0] first, input logic [31:0] stride);
        check_eq({tag, "_len"}, dlog.size(), n);
        for (int i = 0; i < n; i++)
            check_eq(tag, (i < dlog.size()) ? dlog[i] : 32'hDEAD_BEEF, first + stride * i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int req_e[10]   = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        int addr_e[10]  = '{0, 4, 0, 0, 8, 12, 0, 0, 16, 20};
        int valid_e[10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        int pcd_e[10]   = '{0, 0, 0, 0, 0, 4, 0, 0, 8, 12};
        total = 0; bad = 0; cyc = 0; lat = 1; max_infl = 0;
        rst_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem.IMemGnt = 1'b1; imem.IMemRValid = 1'b0; imem.IMemRData = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", ValidD, 1'b0);
        check_eq("rst_instr", InstrD, 32'h13);
        check_eq("rst_pcd", PCD, 32'h0);
        check_eq("rst_pcp4", PCPlus4D, 32'h0);
        check_eq("rst_req", imem.IMemReq, 1'b0);

        // Streaming at latency 1.
        restart(1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("t1_req", imem.IMemReq, 1'b1);
            check_eq("t1_addr", imem.IMemAddr, 4 * c);
            if (c >= 2) begin
                check_eq("t1_valid", ValidD, 1'b1);
                check_eq("t1_pcd", PCD, 4 * (c - 2));
                check_eq("t1_instr", InstrD, 4 * (c - 2) + 32'h100);
                check_eq("t1_pcp4", PCPlus4D, 4 * (c - 2) + 4);
            end else begin
                check_eq("t1_bubble", ValidD, 1'b0);
            end
            tick();
        end

        // Two-cycle StallF/StallD mid-stream.
        StallF = 1'b1; StallD = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("t2_req", imem.IMemReq, 1'b0);
            check_eq("t2_pcd", PCD, 32'd24);
            check_eq("t2_instr", InstrD, 32'h118);
            tick();
        end
        StallF = 1'b0; StallD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check_eq("t2_addr", imem.IMemAddr, 32'd32);
            check_eq("t2_valid", ValidD, 1'b1);
            check_eq("t2_pcd_resume", PCD, 24 + 4 * k);
            tick();
        end
        check_log("t2_log", 10, 32'd0, 32'd4);

        // Latency 3: at most two requests in flight.
        restart(3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("t3_req", imem.IMemReq, req_e[c]);
            if (req_e[c] != 0) check_eq("t3_addr", imem.IMemAddr, addr_e[c]);
            check_eq("t3_valid", ValidD, valid_e[c]);
            if (valid_e[c] != 0) begin
                check_eq("t3_pcd", PCD, pcd_e[c]);
                check_eq("t3_instr", InstrD, pcd_e[c] + 32'h100);
            end
            tick();
        end
        check_eq("t3_max_outstanding", max_infl, 2);
        check_log("t3_log", 4, 32'd0, 32'd4);

        // Redirect with two stale requests in flight.
        restart(3);
        @(negedge clk); tick();
        @(negedge clk); tick();
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        @(negedge clk);
        check_eq("t4_req_redir", imem.IMemReq, 1'b0);
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        check_eq("t4_bubble", ValidD, 1'b0);
        check_eq("t4_bubble_instr", InstrD, 32'h13);
        check_eq("t4_req_wait", imem.IMemReq, 1'b0);
        tick();
        for (int c = 4; c < 8; c++) begin
            @(negedge clk);
            if (c == 4) check_eq("t4_target_addr", imem.IMemAddr, 32'h40);
            if (c == 5) check_eq("t4_next_addr", imem.IMemAddr, 32'h44);
            check_eq("t4_no_stale", ValidD, 1'b0);
            tick();
        end
        @(negedge clk);
        check_eq("t4_valid", ValidD, 1'b1);
        check_eq("t4_pcd", PCD, 32'h40);
        check_eq("t4_instr", InstrD, 32'h140);
        tick();
        check_log("t4_log", 1, 32'h40, 32'd4);

        // One-cycle FlushD with a buffered word.
        restart(1);
        repeat (3) begin @(negedge clk); tick(); end
        StallD = 1'b1;
        @(negedge clk);
        check_eq("t5_pcd_pre", PCD, 32'd4);
        tick();
        StallD = 1'b0; FlushD = 1'b1;
        @(negedge clk);
        check_eq("t5_req_full", imem.IMemReq, 1'b0);
        tick();
        FlushD = 1'b0;
        @(negedge clk);
        check_eq("t5_bubble", ValidD, 1'b0);
        check_eq("t5_bubble_instr", InstrD, 32'h13);
        check_eq("t5_pcd_held", PCD, 32'd4);
        check_eq("t5_pcp4_held", PCPlus4D, 32'd8);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t5_valid", ValidD, 1'b1);
            check_eq("t5_pcd", PCD, 8 + 4 * k);
            check_eq("t5_instr", InstrD, 32'h108 + 4 * k);
            tick();
        end

        // Asynchronous reset mid-stream.
        restart(1);
        repeat (4) begin @(negedge clk); tick(); end
        check_eq("t6_pcd_pre", PCD, 32'd8);
        #2;
        rst_n = 1'b0;
        infl.delete();
        imem.IMemRValid = 1'b0;
        #1;
        check_eq("t6_valid", ValidD, 1'b0);
        check_eq("t6_instr", InstrD, 32'h13);
        check_eq("t6_pcd", PCD, 32'h0);
        check_eq("t6_pcp4", PCPlus4D, 32'h0);
        check_eq("t6_req", imem.IMemReq, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        dlog.delete();
        @(negedge clk);
        check_eq("t6_restart_req", imem.IMemReq, 1'b1);
        check_eq("t6_restart_addr", imem.IMemAddr, 32'h0);
        tick();
        @(negedge clk); tick();
        @(negedge clk);
        check_eq("t6_restart_valid", ValidD, 1'b1);
        check_eq("t6_restart_pcd", PCD, 32'h0);
        check_eq("t6_restart_instr", InstrD, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
